// File: rtl/fifo_reader.sv
// Burst reader: pops len beats from a FIFO with one-cycle read latency and
// streams them through a 3-entry skid buffer onto a valid/ready interface.
module fifo_reader #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 5
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  burst_len,
  output logic              rd,
  input  logic              empty,
  input  logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  beat_count
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  issued_q, issued_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic              inflight_q;
  logic [1:0]        occ_q, occ_d;
  logic [1:0]        wr_ptr_q, wr_ptr_d;
  logic [1:0]        rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] buf_q [3];

  logic              push;
  logic              pop;
  logic [2:0]        pending;

  // A read still in flight reserves a buffer slot, so the buffer never overflows.
  assign pending = {1'b0, occ_q} + {2'b00, inflight_q};
  assign push    = inflight_q;
  assign m_valid = (occ_q != 2'd0);
  assign pop     = m_valid && m_ready;
  assign m_data  = m_valid ? buf_q[rd_ptr_q] : '0;
  assign m_last  = m_valid && (beat_q == len_q - LEN_W'(1));
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign beat_count = beat_q;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    issued_d = issued_q;
    beat_d   = beat_q;
    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rd       = 1'b0;

    if (pop) begin
      beat_d   = beat_q + LEN_W'(1);
      rd_ptr_d = (rd_ptr_q == 2'd2) ? 2'd0 : rd_ptr_q + 2'd1;
    end
    if (push) begin
      wr_ptr_d = (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase

    case (state_q)
      IDLE: begin
        if (start && (burst_len != '0)) begin
          state_d  = RUN;
          len_d    = burst_len;
          issued_d = '0;
          beat_d   = '0;
        end
      end
      RUN: begin
        rd = !empty && (issued_q < len_q) && (pending < 3'd3);
        if (rd) issued_d = issued_q + LEN_W'(1);
        if (issued_q == len_q) state_d = DRAIN;
      end
      DRAIN: begin
        // Finish as the last beat leaves so done follows it by one cycle.
        if (!inflight_q && ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop))) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples its pre-edge inputs regardless of process ordering.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      beat_q     <= '0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      beat_q     <= beat_d;
      inflight_q <= rd;
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // NOTE: buffer storage is not reset; occ_q qualifies every entry and m_data
  // is forced to zero while the buffer is empty.
  always_ff @(posedge clock) begin
    if (push) buf_q[wr_ptr_q] <= data_out;
  end

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader: a queue stands in for the FIFO (one-cycle
// read latency) and every stream beat is recorded and compared to hand values.
module tb_fifo_reader;

  localparam int DATA_W = 8;
  localparam int LEN_W  = 5;

  logic              clock = 1'b0;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  burst_len;
  logic              rd;
  logic              empty;
  logic [DATA_W-1:0] data_out;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  beat_count;

  fifo_reader #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clock      (clock),
    .rst        (rst),
    .start      (start),
    .burst_len  (burst_len),
    .rd         (rd),
    .empty      (empty),
    .data_out   (data_out),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .busy       (busy),
    .done       (done),
    .beat_count (beat_count)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] fifo_q[$];
  logic [7:0] got_q[$];
  int         got_cyc[$];
  bit         got_last[$];
  int cyc, rd_cnt, rd_empty, done_cnt, done_cyc, first_rd, first_val, last_cnt, unstable;
  logic       prev_stall;
  logic [7:0] prev_data;

  task automatic clear_mon();
    rd_cnt = 0; rd_empty = 0; done_cnt = 0; done_cyc = -1;
    first_rd = -1; first_val = -1; last_cnt = 0; unstable = 0;
    prev_stall = 1'b0; prev_data = '0;
    got_q.delete(); got_cyc.delete(); got_last.delete();
  endtask

  task automatic fifo_reset();
    fifo_q.delete();
    empty    = 1'b1;
    data_out = '0;
  endtask

  task automatic push(input logic [7:0] v);
    fifo_q.push_back(v);
    empty = 1'b0;
  endtask

  // Called at a falling edge: observe the cycle just before the rising edge
  // consumes it, then advance to the next falling edge and play the FIFO.
  task automatic step();
    logic rd_s;
    #1;
    cyc++;
    rd_s = rd;
    if (rd) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
      if (empty) rd_empty++;
    end
    if (m_valid && first_val < 0) first_val = cyc;
    if (m_valid && !m_ready && prev_stall && m_data !== prev_data) unstable++;
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    if (m_valid && m_ready) begin
      got_q.push_back(m_data);
      got_cyc.push_back(cyc);
      got_last.push_back(m_last);
      if (m_last) last_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(negedge clock);
    if (rd_s && fifo_q.size() > 0) data_out = fifo_q.pop_front();
    empty = (fifo_q.size() == 0);
  endtask

  task automatic start_burst(input int len);
    burst_len = LEN_W'(len);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) step();
  endtask

  task automatic check_beats(input string tag, input logic [7:0] base, input int n);
    check({tag, "_nbeats"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++)
      check({tag, "_data"}, got_q[i], base + i);
    check({tag, "_last_cnt"}, last_cnt, 1);
    if (got_q.size() > 0) check({tag, "_last_pos"}, got_last[got_q.size()-1], 1);
    check({tag, "_beat_count"}, beat_count, n);
    check({tag, "_done_cnt"}, done_cnt, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd"}, rd, 0);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_last"}, m_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_beat_count"}, beat_count, 0);
    check({tag, "_m_data"}, m_data, 0);
  endtask

  initial begin
    int t0;
    int pushed;
    rst = 1'b1; start = 1'b0; burst_len = '0; m_ready = 1'b1; cyc = 0;
    fifo_reset();
    clear_mon();

    // Reset state
    repeat (2) @(negedge clock);
    #1;
    check_reset_outputs("reset");
    @(negedge clock);
    rst = 1'b0;

    // 20-beat burst at full rate
    fifo_reset();
    for (int i = 1; i <= 20; i++) push(8'(i));
    clear_mon();
    start_burst(20);
    t0 = cyc;
    run_done(60);
    check("b20_first_rd", first_rd, t0 + 1);
    check("b20_first_valid", first_val, t0 + 3);
    check_beats("b20", 8'h01, 20);
    if (got_cyc.size() == 20) begin
      check("b20_consecutive", got_cyc[19] - got_cyc[0], 19);
      check("b20_done_after_last", done_cyc, got_cyc[19] + 1);
    end
    repeat (3) step();
    check("b20_beat_count_hold", beat_count, 20);
    check("b20_idle_busy", busy, 0);

    // FIFO starts empty, writes trickle in every 3 cycles
    fifo_reset();
    clear_mon();
    start_burst(5);
    pushed = 0;
    for (int i = 0; i < 80 && done_cnt == 0; i++) begin
      if (pushed < 5 && (i % 3) == 2) begin
        push(8'h30 + 8'(pushed));
        pushed++;
      end
      step();
    end
    check("trickle_rd_while_empty", rd_empty, 0);
    check("trickle_rd_cnt", rd_cnt, 5);
    check_beats("trickle", 8'h30, 5);

    // Downstream stall for 10 cycles
    fifo_reset();
    for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
    clear_mon();
    m_ready = 1'b0;
    start_burst(8);
    repeat (10) step();
    check("stall_rd_cnt", rd_cnt, 3);
    check("stall_m_data_stable", unstable, 0);
    check("stall_m_valid", m_valid, 1);
    check("stall_m_data_head", m_data, 8'h40);
    m_ready = 1'b1;
    run_done(40);
    check_beats("stall", 8'h40, 8);
    check("stall_rd_total", rd_cnt, 8);

    // Zero-length request is ignored
    fifo_reset();
    push(8'hA0); push(8'hA1);
    clear_mon();
    start_burst(0);
    repeat (4) step();
    check("len0_busy", busy, 0);
    check("len0_rd_cnt", rd_cnt, 0);
    check("len0_fifo_untouched", fifo_q.size(), 2);

    // Second start while running is ignored
    fifo_reset();
    for (int i = 0; i < 6; i++) push(8'h60 + 8'(i));
    clear_mon();
    start_burst(2);
    burst_len = 5'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    run_done(30);
    check_beats("restart", 8'h60, 2);
    repeat (3) step();
    check("restart_busy", busy, 0);
    check("restart_fifo_left", fifo_q.size(), 4);

    // Reset mid-burst, then a fresh 4-beat burst
    fifo_reset();
    for (int i = 0; i < 10; i++) push(8'h70 + 8'(i));
    clear_mon();
    start_burst(10);
    for (int i = 0; i < 40 && got_q.size() < 3; i++) step();
    check("midrst_beats_before", got_q.size(), 3);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clock);
    fifo_reset();
    for (int i = 0; i < 4; i++) push(8'h80 + 8'(i));
    clear_mon();
    rst = 1'b0;
    start_burst(4);
    run_done(30);
    check_beats("after_rst", 8'h80, 4);

    // Maximum length with random ready and random FIFO writes
    fifo_reset();
    clear_mon();
    start_burst(31);
    pushed = 0;
    for (int i = 0; i < 600 && done_cnt == 0; i++) begin
      if (pushed < 31 && $urandom_range(0, 1) == 1) begin
        push(8'h90 + 8'(pushed));
        pushed++;
      end
      m_ready = 1'($urandom_range(0, 1));
      step();
    end
    check("rand_rd_while_empty", rd_empty, 0);
    check_beats("rand", 8'h90, 31);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter DATA_W, default 8, width of FIFO data and output stream data.
REQ-002 Parameter LEN_W, default 5, width of burst length and beat counter.
REQ-003 The block SHALL have exactly one clock, clock; reset rst SHALL be asynchronous and active-high.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 start  input  1  one-cycle burst request, sampled only in IDLE.
REQ-007 burst_len  input  LEN_W  beats to read, sampled with start; 0 = request ignored.
REQ-008 rd  output  1  FIFO pop strobe; connects to the FIFO wr/rd port pair's rd.
REQ-009 empty  input  1  FIFO empty flag.
REQ-010 data_out  input  DATA_W  FIFO read data, valid the cycle after rd.
REQ-011 m_data  output  DATA_W  output stream data.
REQ-012 m_valid  output  1  output beat valid.
REQ-013 m_ready  input  1  downstream accept; a beat transfers when m_valid && m_ready.
REQ-014 m_last  output  1  high with the final beat of a burst.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse at burst completion.
REQ-017 beat_count  output  LEN_W  beats transferred in the current/last burst.

Function
REQ-018 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-019 IDLE->RUN on start && burst_len!=0; latch len, clear issued count and beat_count. start in any other state is ignored.
REQ-020 RUN: rd = !empty && issued<len && (occ+inflight)<3, where occ = skid-buffer entries (0..3) and inflight = rd registered from the previous cycle.
REQ-021 rd SHALL be a function of registered state and empty only; never asserted while empty=1 or outside RUN.
REQ-022 RUN->DRAIN in the cycle after issued reaches len.
REQ-023 DRAIN->DONE when inflight=0, occ=0, and no beat pending.
REQ-024 DONE lasts one cycle with done=1, then returns to IDLE.
REQ-025 data_out SHALL be written into a 3-entry in-order skid buffer on the edge ending the cycle after rd; m_valid is high the following cycle.
REQ-026 m_data/m_valid SHALL come from the buffer head; m_data holds stable while m_valid && !m_ready.
REQ-027 Simultaneous buffer write and pop SHALL leave occ unchanged, with no data loss or reorder.
REQ-028 Sustained throughput SHALL be one beat per cycle when the FIFO is non-empty and m_ready=1.
REQ-029 Latency: start sampled at edge 0 -> rd in cycle 1 (if !empty) -> m_valid in cycle 3.
REQ-030 m_last = m_valid && (beat_count == len-1).
REQ-031 beat_count SHALL increment on each transfer and hold its value after DONE until the next accepted start.
REQ-032 empty asserting mid-burst SHALL stall rd without a state change; reading resumes when empty deasserts.
REQ-033 m_ready=0 SHALL stall rd once occ+inflight=3; no FIFO data is lost.
REQ-034 burst_len = 2^LEN_W-1 SHALL complete without counter overflow.

Reset
REQ-035 While rst=1: state=IDLE, occ=0, inflight=0, rd=0, m_valid=0, m_last=0, busy=0, done=0, beat_count=0, m_data=0.
REQ-036 Reset mid-burst SHALL take effect immediately, discard the buffer and any in-flight read, and leave the block accepting start on the first edge after release.

Verification
REQ-037 FIFO preloaded with 20 bytes 0x01..0x14, m_ready=1, start, len=20 -> 20 beats 0x01..0x14 on consecutive cycles; m_last on 0x14; done one cycle later; beat_count=20.
REQ-038 len=5 with FIFO empty, then 5 writes spaced 3 cycles apart -> rd only when !empty, 5 beats in order, no rd while empty.
REQ-039 len=8, m_ready=0 for 10 cycles then 1 -> exactly 3 rd pulses during the stall, m_data stable, all 8 beats in order afterwards.
REQ-040 start with len=0 -> stays IDLE, busy=0, rd never asserts; start during RUN -> ignored.
REQ-041 rst pulsed after 3 of 10 beats -> all outputs at reset values immediately; a new start with len=4 after release -> 4 beats with correct m_last.
REQ-042 Random m_ready (50%) and random FIFO writes, len=31 -> scoreboard matches FIFO order, beat_count=31, no rd while empty.
